// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response port: one outstanding fetch at a time.
interface ifu_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/ifu_fetch.sv
// Fetch and next-PC unit for the single-cycle MIPS core.
// A fetch/execute sequence lets instruction memory have variable latency.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               nPC_sel_i,
  input  logic               j_sel_i,
  input  logic               zero_i,
  input  logic               stall_i,
  ifu_fetch_if.master        imem,
  output logic [31:0]        instr_o,
  output logic [5:0]         type_o,
  output logic [5:0]         LSBs_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        pc_plus4_o,
  output logic               instr_valid_o,
  output logic               err_spurious_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] next_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  assign pc_plus4  = pc_q + 32'd4;
  assign br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Jump beats branch when the decoder raises both selects.
  always_comb begin
    next_pc = pc_plus4;
    if (j_sel_i) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (nPC_sel_i && zero_i) begin
      next_pc = pc_plus4 + br_offset;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q | (imem.imem_rvalid && (state_q != S_WAIT));
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          instr_d = imem.imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall_i) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;

  assign instr_o        = instr_q;
  assign type_o         = instr_q[31:26];
  assign LSBs_o         = instr_q[5:0];
  assign pc_o           = pc_q;
  assign pc_plus4_o     = pc_plus4;
  assign instr_valid_o  = (state_q == S_EXEC);
  assign err_spurious_o = err_q;

endmodule
